opsum_collector: RTL and testbench

- Downstream consumer of the GON output network.
- Walks (row_tag, col_tag) across the active PE sub-array and drives the GON ready/tag request.
- Captures each returned opsum value, applies optional ReLU, and computes a linear buffer address.
- Buffers results in a small FIFO and streams them as writes to the global buffer (GLB) under a valid/ready handshake.

---
 rtl/opsum_pkg.sv | 22 ++
 rtl/opsum_collector_if.sv | 36 +++
 rtl/opsum_fifo.sv | 50 +++++
 rtl/opsum_collector.sv | 98 +++++++++
 tb/tb_opsum_collector.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opsum_pkg.sv
// opsum_pkg: shared sizes, collector state encoding, FIFO entry layout and ReLU helper
package opsum_pkg;
  localparam int XBUS_NUMS  = 12;
  localparam int PE_NUMS    = 14;
  localparam int ID_LEN     = 5;
  localparam int ROW_LEN    = 4;
  localparam int VALUE_LEN  = 32;
  localparam int ADDR_LEN   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_LEN    = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [ADDR_LEN-1:0]  addr;
    logic [VALUE_LEN-1:0] data;
  } entry_t;

  function automatic logic [VALUE_LEN-1:0] relu(input logic en, input logic [VALUE_LEN-1:0] v);
    return (en && v[VALUE_LEN-1]) ? '0 : v;
  endfunction
endpackage

// File: rtl/opsum_collector_if.sv
// opsum_collector_if: control, GON request/response and GLB write signals of the collector
//   master: collector side (drives busy/done, GON request, GLB write)
//   slave : environment side (drives start/config, GON response, GLB ready)
interface opsum_collector_if;
  import opsum_pkg::*;
  logic                 start_i;
  logic [ROW_LEN-1:0]   num_rows_i;
  logic [ID_LEN-1:0]    num_cols_i;
  logic [ADDR_LEN-1:0]  base_addr_i;
  logic                 relu_en_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 gon_ready_o;
  logic [ROW_LEN-1:0]   gon_row_tag_o;
  logic [ID_LEN-1:0]    gon_col_tag_o;
  logic                 gon_enable_i;
  logic [VALUE_LEN-1:0] gon_value_i;
  logic                 glb_wen_o;
  logic [ADDR_LEN-1:0]  glb_waddr_o;
  logic [VALUE_LEN-1:0] glb_wdata_o;
  logic                 glb_wready_i;

  modport master (
    input  start_i, num_rows_i, num_cols_i, base_addr_i, relu_en_i,
           gon_enable_i, gon_value_i, glb_wready_i,
    output busy_o, done_o, gon_ready_o, gon_row_tag_o, gon_col_tag_o,
           glb_wen_o, glb_waddr_o, glb_wdata_o
  );

  modport slave (
    output start_i, num_rows_i, num_cols_i, base_addr_i, relu_en_i,
           gon_enable_i, gon_value_i, glb_wready_i,
    input  busy_o, done_o, gon_ready_o, gon_row_tag_o, gon_col_tag_o,
           glb_wen_o, glb_waddr_o, glb_wdata_o
  );
endinterface

// File: rtl/opsum_fifo.sv
// opsum_fifo: synchronous FIFO, power-of-two DEPTH, asynchronous active-low reset
//   push_i/wdata_i write side; pop_i/rdata_o read side (rdata_o is the head)
//   full_o, empty_o, count_o report occupancy
module opsum_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  logic push, pop;

  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign full_o  = count_q == (PW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/opsum_collector.sv
// opsum_collector: walks the active PE sub-array over GON, applies optional ReLU and streams results to GLB
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/config in, busy/done out, GON ready/tag out + enable/value in,
//                GLB wen/waddr/wdata out + wready in
module opsum_collector import opsum_pkg::*; (
  input logic               clk,
  input logic               rst_n,
  opsum_collector_if.master bus
);
  state_e state_q, state_d;
  logic [ROW_LEN-1:0] row_q, row_d, rows_q, rows_d, rows_in;
  logic [ID_LEN-1:0] col_q, col_d, cols_q, cols_d, cols_in;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic relu_q, relu_d;
  logic accept, pop, full, empty, last_col, last_row;
  logic [CNT_LEN-1:0] count;
  entry_t push_e, head_e;

  assign rows_in  = bus.num_rows_i > ROW_LEN'(XBUS_NUMS) ? ROW_LEN'(XBUS_NUMS) : bus.num_rows_i;
  assign cols_in  = bus.num_cols_i > ID_LEN'(PE_NUMS) ? ID_LEN'(PE_NUMS) : bus.num_cols_i;
  assign last_col = col_q == cols_q - 1'b1;
  assign last_row = row_q == rows_q - 1'b1;
  assign accept   = bus.gon_ready_o & bus.gon_enable_i;
  assign pop      = bus.glb_wen_o & bus.glb_wready_i;
  // Row-major walk means base + row*cols + col is just the base advanced once per accept.
  assign push_e   = '{addr: addr_q, data: relu(relu_q, bus.gon_value_i)};

  assign bus.busy_o        = state_q != IDLE;
  assign bus.done_o        = state_q == DONE;
  assign bus.gon_ready_o   = state_q == REQ && !full;
  assign bus.gon_row_tag_o = row_q;
  assign bus.gon_col_tag_o = col_q;
  assign bus.glb_wen_o     = !empty;
  // Head storage is not reset, so mask it while empty to keep the write bus at zero.
  assign bus.glb_waddr_o   = empty ? '0 : head_e.addr;
  assign bus.glb_wdata_o   = empty ? '0 : head_e.data;

  opsum_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (push_e),
    .rdata_o (head_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    addr_d  = addr_q;
    relu_d  = relu_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        rows_d  = rows_in;
        cols_d  = cols_in;
        addr_d  = bus.base_addr_i;
        relu_d  = bus.relu_en_i;
        row_d   = '0;
        col_d   = '0;
        state_d = (rows_in == '0 || cols_in == '0) ? DONE : REQ;
      end
      REQ: if (accept) begin
        addr_d  = addr_q + 1'b1;
        col_d   = last_col ? '0 : col_q + 1'b1;
        row_d   = last_col ? row_q + 1'b1 : row_q;
        state_d = (last_col && last_row) ? DRAIN : REQ;
      end
      DRAIN: state_d = count == '0 ? DONE : DRAIN;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      addr_q  <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      addr_q  <= addr_d;
      relu_q  <= relu_d;
    end
endmodule

// File: tb/tb_opsum_collector.sv
// tb_opsum_collector: randomized self-checking bench for opsum_collector against a row-major walk model
module tb_opsum_collector;
  import opsum_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [VALUE_LEN-1:0] vals[$];
  logic [VALUE_LEN-1:0] wr_log[$];
  logic [ADDR_LEN-1:0] last_addr;
  int acc_at_stall, done_cyc;
  logic ready_at_stall;
  logic [ID_LEN-1:0] col_at_stall;

  opsum_collector_if bus();
  opsum_collector dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive_idle;
    bus.start_i      = 1'b0;
    bus.num_rows_i   = '0;
    bus.num_cols_i   = '0;
    bus.base_addr_i  = '0;
    bus.relu_en_i    = 1'b0;
    bus.gon_enable_i = 1'b0;
    bus.gon_value_i  = '0;
    bus.glb_wready_i = 1'b0;
  endtask

  task automatic run_pass(input int nr, input int nc, input logic [ADDR_LEN-1:0] base,
                          input logic relu, input int en_pct, input int wr_pct, input int stall);
    int er, ec, total, k, w, dones, cyc;
    logic [ADDR_LEN+VALUE_LEN-1:0] expq[$];
    logic [ADDR_LEN-1:0] ea, pa;
    logic [VALUE_LEN-1:0] v, pd;
    logic stalled, rdy;
    er = nr > XBUS_NUMS ? XBUS_NUMS : nr;
    ec = nc > PE_NUMS ? PE_NUMS : nc;
    total = er * ec;
    k = 0; w = 0; dones = 0; cyc = 0; stalled = 1'b0; pa = '0; pd = '0;
    done_cyc = -1;
    wr_log.delete();
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.num_rows_i  = ROW_LEN'(nr);
    bus.num_cols_i  = ID_LEN'(nc);
    bus.base_addr_i = base;
    bus.relu_en_i   = relu;
    forever begin
      @(negedge clk);
      cyc++;
      bus.start_i     = (cyc == 3) && bus.busy_o;
      bus.num_rows_i  = ROW_LEN'($urandom);
      bus.num_cols_i  = ID_LEN'($urandom);
      bus.base_addr_i = ADDR_LEN'($urandom);
      bus.relu_en_i   = 1'($urandom);
      if (bus.done_o) begin
        dones++;
        done_cyc = cyc;
        checks++;
        if (bus.busy_o !== 1'b1 || bus.glb_wen_o !== 1'b0) begin
          errors++;
          $display("FAIL done_state busy=%0b wen=%0b required busy=1 wen=0", bus.busy_o, bus.glb_wen_o);
        end
      end
      rdy = bus.gon_ready_o;
      if (rdy) begin
        checks++;
        if (k >= total) begin
          errors++;
          $display("FAIL ready_after_last accepts=%0d required total=%0d", k, total);
        end else if (bus.gon_row_tag_o !== ROW_LEN'(k / ec) || bus.gon_col_tag_o !== ID_LEN'(k % ec)) begin
          errors++;
          $display("FAIL tag got (%0d,%0d) required (%0d,%0d)", bus.gon_row_tag_o, bus.gon_col_tag_o, k / ec, k % ec);
        end
      end
      bus.gon_enable_i = $urandom_range(99) < en_pct;
      v = vals.size() > 0 ? vals[0] : $urandom;
      bus.gon_value_i = v;
      if (rdy && bus.gon_enable_i && k < total) begin
        if (vals.size() > 0) vals.delete(0);
        ea = ADDR_LEN'(int'(base) + (k / ec) * ec + (k % ec));
        expq.push_back({ea, (relu && v[VALUE_LEN-1]) ? '0 : v});
        k++;
      end
      if (cyc == stall) begin
        acc_at_stall   = k;
        ready_at_stall = bus.gon_ready_o;
        col_at_stall   = bus.gon_col_tag_o;
      end
      if (stalled) begin
        checks++;
        if (bus.glb_wen_o !== 1'b1 || bus.glb_waddr_o !== pa || bus.glb_wdata_o !== pd) begin
          errors++;
          $display("FAIL stall_hold got wen=%0b %h/%h required wen=1 %h/%h", bus.glb_wen_o, bus.glb_waddr_o, bus.glb_wdata_o, pa, pd);
        end
      end
      bus.glb_wready_i = (cyc > stall) && ($urandom_range(99) < wr_pct);
      if (bus.glb_wen_o && bus.glb_wready_i) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL extra_write got %h/%h required none", bus.glb_waddr_o, bus.glb_wdata_o);
        end else if ({bus.glb_waddr_o, bus.glb_wdata_o} !== expq[0]) begin
          errors++;
          $display("FAIL write got %h/%h required %h/%h", bus.glb_waddr_o, bus.glb_wdata_o,
                   expq[0][ADDR_LEN+VALUE_LEN-1:VALUE_LEN], expq[0][VALUE_LEN-1:0]);
        end
        if (expq.size() > 0) expq.delete(0);
        wr_log.push_back(bus.glb_wdata_o);
        last_addr = bus.glb_waddr_o;
        w++;
      end
      stalled = bus.glb_wen_o && !bus.glb_wready_i;
      pa = bus.glb_waddr_o;
      pd = bus.glb_wdata_o;
      if (dones > 0) break;
      if (cyc > 3000) begin
        errors++;
        $display("FAIL timeout waited %0d cycles required done", cyc);
        break;
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.gon_enable_i = 1'b0;
    bus.glb_wready_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done busy=%0b done=%0b required 0 0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (k != total || w != total || dones != 1 || expq.size() != 0) begin
      errors++;
      $display("FAIL pass_count accepts=%0d writes=%0d dones=%0d left=%0d required %0d %0d 1 0",
               k, w, dones, expq.size(), total, total);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.gon_ready_o, bus.gon_row_tag_o, bus.gon_col_tag_o,
         bus.glb_wen_o, bus.glb_waddr_o, bus.glb_wdata_o} !== '0) begin
      errors++;
      $display("FAIL %s busy=%0b done=%0b rdy=%0b tag=(%0d,%0d) wen=%0b %h/%h required all 0", name,
               bus.busy_o, bus.done_o, bus.gon_ready_o, bus.gon_row_tag_o, bus.gon_col_tag_o,
               bus.glb_wen_o, bus.glb_waddr_o, bus.glb_wdata_o);
    end
  endtask

  task automatic test_reset;
    drive_idle();
    #2;
    check_outputs_zero("reset_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_basic;
    run_pass(2, 3, 16'h0100, 1'b0, 100, 100, 0);
    checks++;
    if (last_addr !== 16'h0105) begin
      errors++;
      $display("FAIL basic_last_addr got %h required 0105", last_addr);
    end
    run_pass(2, 3, 16'h0100, 1'b0, 50, 60, 0);
    run_pass(3, 5, ADDR_LEN'($urandom), 1'b1, 70, 70, 0);
  endtask

  task automatic test_full;
    run_pass(12, 14, 16'hFFF0, 1'b0, 85, 75, 0);
    checks++;
    if (last_addr !== 16'h0097) begin
      errors++;
      $display("FAIL full_last_addr got %h required 0097", last_addr);
    end
    run_pass(15, 31, ADDR_LEN'($urandom), 1'b1, 90, 90, 0);
    run_pass(3, 20, 16'h4000, 1'b0, 60, 100, 0);
  endtask

  task automatic test_stall;
    run_pass(1, 8, 16'h0020, 1'b0, 100, 100, 20);
    checks++;
    if (acc_at_stall != 4 || ready_at_stall !== 1'b0 || col_at_stall !== ID_LEN'(4)) begin
      errors++;
      $display("FAIL stall_fill accepts=%0d ready=%0b col=%0d required 4 0 4", acc_at_stall, ready_at_stall, col_at_stall);
    end
  endtask

  task automatic test_relu;
    logic [VALUE_LEN-1:0] exp_on[3];
    logic [VALUE_LEN-1:0] exp_off[3];
    exp_on  = '{32'h0, 32'h5, 32'h0};
    exp_off = '{32'h80000001, 32'h5, 32'hFFFFFFFF};
    vals = '{32'h80000001, 32'h00000005, 32'hFFFFFFFF};
    run_pass(1, 3, 16'h0300, 1'b1, 100, 100, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_log.size() != 3 || wr_log[i] !== exp_on[i]) begin
        errors++;
        $display("FAIL relu_on[%0d] got %h required %h", i, wr_log.size() > i ? wr_log[i] : 'x, exp_on[i]);
      end
    end
    vals = '{32'h80000001, 32'h00000005, 32'hFFFFFFFF};
    run_pass(1, 3, 16'h0300, 1'b0, 100, 100, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_log.size() != 3 || wr_log[i] !== exp_off[i]) begin
        errors++;
        $display("FAIL relu_off[%0d] got %h required %h", i, wr_log.size() > i ? wr_log[i] : 'x, exp_off[i]);
      end
    end
  endtask

  task automatic test_zero;
    run_pass(4, 0, 16'h0500, 1'b0, 100, 100, 0);
    checks++;
    if (done_cyc != 1) begin
      errors++;
      $display("FAIL zero_cols done at cycle %0d required 1", done_cyc);
    end
    run_pass(0, 6, 16'h0500, 1'b0, 100, 100, 0);
    checks++;
    if (done_cyc != 1) begin
      errors++;
      $display("FAIL zero_rows done at cycle %0d required 1", done_cyc);
    end
  endtask

  task automatic test_abort;
    int acc, cyc;
    acc = 0; cyc = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.num_rows_i = 4'd1;
    bus.num_cols_i = 5'd8;
    bus.base_addr_i = 16'h0200;
    bus.gon_enable_i = 1'b1;
    bus.glb_wready_i = 1'b0;
    while (acc < 2 && cyc < 50) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      cyc++;
      if (bus.gon_ready_o && bus.gon_enable_i) acc++;
    end
    @(negedge clk);
    bus.gon_enable_i = 1'b0;
    checks++;
    if (acc != 2 || bus.glb_wen_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup accepts=%0d wen=%0b required 2 1", acc, bus.glb_wen_o);
    end
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("abort_async");
    repeat (2) @(negedge clk);
    check_outputs_zero("abort_held");
    rst_n = 1'b1;
    run_pass(1, 1, 16'h0700, 1'b0, 100, 100, 0);
    checks++;
    if (last_addr !== 16'h0700 || wr_log.size() != 1) begin
      errors++;
      $display("FAIL abort_restart addr=%h writes=%0d required 0700 1", last_addr, wr_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_relu();
    test_zero();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
